uart_reg_responder: RTL and testbench

- Byte-level command responder on the host side of the UART core.
- Consumes received bytes (rx_dfifo/rx_busy/rx_parity_err) and parses a 2- or 3-byte register-access frame against an internal register file.
- Returns a one-byte response through the transmit side (tx_en/tx_dfifo/tx_busy).
- Half-duplex slave: the remote host is the initiator, this block is the responder.

---
 rtl/uart_reg_responder.sv | 170 +++++++++++++++++
 tb/tb_uart_reg_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Register-file responder for UART frames (W addr data / R addr), one response byte each.
// Latency: final byte_stb -> tx_en next cycle; tx_en waits for tx_busy low, extra rx bytes during response are dropped.
module uart_reg_responder #(
  parameter int NREG        = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_dfifo,
  input  logic              rx_busy,
  input  logic              rx_parity_err,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_dfifo,
  output logic [NREG*8-1:0] regs,
  output logic              wr_stb,
  output logic [7:0]        wr_addr
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [8:0]      NREG_LIM = 9'(NREG);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      CMD_WR   = 8'h57;
  localparam logic [7:0]      CMD_RD   = 8'h52;
  localparam logic [7:0]      RSP_OK   = 8'h4B;
  localparam logic [7:0]      RSP_ERR  = 8'h45;
  localparam logic [7:0]      RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TX_REQ, TX_WAIT} state_e;

  state_e          state_q, state_d;
  logic            rx_busy_q, rx_busy_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic [7:0]      regs_q [NREG];
  logic [7:0]      regs_d [NREG];
  logic            wr_stb_q, wr_stb_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            busy_seen_q, busy_seen_d;
  logic [1:0]      wait_cnt_q, wait_cnt_d;

  logic            byte_stb;
  logic            byte_ok;
  logic            addr_ok;
  logic [7:0]      rd_dat;

  assign byte_stb = rx_busy_q & ~rx_busy;
  assign byte_ok  = {1'b0, rx_dfifo} < NREG_LIM;
  assign addr_ok  = {1'b0, addr_q} < NREG_LIM;

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rx_dfifo == 8'(i)) rd_dat = regs_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_busy_d   = rx_busy;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    tx_dat_d    = tx_dat_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    to_cnt_d    = '0;
    busy_seen_d = busy_seen_q;
    wait_cnt_d  = wait_cnt_q;
    tx_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (byte_stb) begin
          if (!rx_parity_err && (rx_dfifo == CMD_WR || rx_dfifo == CMD_RD)) begin
            is_wr_d = (rx_dfifo == CMD_WR);
            state_d = ADDR;
          end else begin
            tx_dat_d = RSP_BAD;
            state_d  = TX_REQ;
          end
        end
      end
      ADDR, DATA: begin
        if (byte_stb) begin
          state_d = TX_REQ;
          if (rx_parity_err) begin
            tx_dat_d = RSP_BAD;
          end else if (state_q == ADDR) begin
            addr_d = rx_dfifo;
            if (is_wr_q) state_d  = DATA;
            else         tx_dat_d = byte_ok ? rd_dat : RSP_ERR;
          end else if (addr_ok) begin
            for (int i = 0; i < NREG; i++) begin
              if (addr_q == 8'(i)) regs_d[i] = rx_dfifo;
            end
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            tx_dat_d  = RSP_OK;
          end else begin
            tx_dat_d = RSP_ERR;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      TX_REQ: begin
        if (!tx_busy) begin
          tx_en       = 1'b1;
          busy_seen_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // Give up after 4 cycles if the transmitter never acknowledged tx_en.
        if (busy_seen_q) begin
          if (!tx_busy) state_d = IDLE;
        end else if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (wait_cnt_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rx_busy_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      tx_dat_q    <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      to_cnt_q    <= '0;
      busy_seen_q <= 1'b0;
      wait_cnt_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rx_busy_q   <= rx_busy_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      tx_dat_q    <= tx_dat_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      to_cnt_q    <= to_cnt_d;
      busy_seen_q <= busy_seen_d;
      wait_cnt_q  <= wait_cnt_d;
      regs_q      <= regs_d;
    end
  end

  assign tx_dfifo = tx_dat_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs[g*8 +: 8] = regs_q[g];
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: UART rx byte driver, tx responder model,
// expected response bytes queued per frame and compared on each tx_en.
module tb_uart_reg_responder;

  localparam int NREG = 16;
  localparam int TO   = 50;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        rx_dfifo = '0;
  logic              rx_busy = 1'b0;
  logic              rx_parity_err = 1'b0;
  logic              tx_busy_auto = 1'b0;
  logic              tx_hold = 1'b0;
  logic              tx_busy;
  logic              tx_en;
  logic [7:0]        tx_dfifo;
  logic [NREG*8-1:0] regs;
  logic              wr_stb;
  logic [7:0]        wr_addr;

  assign tx_busy = tx_busy_auto | tx_hold;

  uart_reg_responder #(.NREG(NREG), .TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .rx_dfifo      (rx_dfifo),
    .rx_busy       (rx_busy),
    .rx_parity_err (rx_parity_err),
    .tx_busy       (tx_busy),
    .tx_en         (tx_en),
    .tx_dfifo      (tx_dfifo),
    .regs          (regs),
    .wr_stb        (wr_stb),
    .wr_addr       (wr_addr)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [NREG];
  int         tx_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr = '0;
  longint     stb_edge = 0;
  longint     tx_edge = 0;
  int         busy_len = 5;
  logic       mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NREG*8-1:0] model_flat();
    logic [NREG*8-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      wr_cnt++;
      last_wr_addr = wr_addr;
    end
    if (tx_en === 1'b1) tx_cnt++;
  end

  // Transmitter model: checks each requested byte, then stays busy for busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        mon_busy = 1'b1;
        tx_edge  = $time;
        if (exp_q.size() == 0) chk("tx_unexpected_qsize", exp_q.size(), 1);
        else                   chk("tx_byte", tx_dfifo, exp_q.pop_front());
        @(posedge clk); #1 tx_busy_auto = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy_auto = 1'b0;
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic perr);
    repeat (2) @(posedge clk);
    #1 rx_dfifo = b; rx_parity_err = perr; rx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_busy = 1'b0;
    @(posedge clk);
    stb_edge = $time;
    #1 rx_parity_err = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || tx_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("resp_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57, 1'b0);
    send_byte(a, 1'b0);
    if (a < NREG) begin
      exp_q.push_back(8'h4B);
      model[a[3:0]] = d;
    end else begin
      exp_q.push_back(8'h45);
    end
    send_byte(d, 1'b0);
    wait_resp();
  endtask

  task automatic do_read(input logic [7:0] a);
    send_byte(8'h52, 1'b0);
    if (a < NREG) exp_q.push_back(model[a[3:0]]);
    else          exp_q.push_back(8'h45);
    send_byte(a, 1'b0);
    wait_resp();
  endtask

  initial begin
    int w0;
    int t0;
    int n;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_dfifo", tx_dfifo, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_regs", regs, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Write then read back
    w0 = wr_cnt;
    do_write(8'h03, 8'hA5);
    chk("wr_stb_pulses", wr_cnt - w0, 1);
    chk("wr_addr", last_wr_addr, 8'h03);
    chk("reg3", regs[31:24], 8'hA5);
    chk("regs_after_wr", regs, model_flat());
    do_read(8'h03);
    chk("rd_latency", tx_edge - stb_edge, 5);

    // Address range boundaries
    w0 = wr_cnt;
    do_write(8'h20, 8'h11);
    chk("bad_wr_no_stb", wr_cnt - w0, 0);
    chk("regs_after_bad_wr", regs, model_flat());
    do_read(8'h10);
    do_write(8'h0F, 8'h3C);
    chk("wr_addr_top", last_wr_addr, 8'h0F);
    do_read(8'h0F);

    // Unknown command and parity errors
    exp_q.push_back(8'h3F);
    send_byte(8'h00, 1'b0);
    wait_resp();
    w0 = wr_cnt;
    send_byte(8'h57, 1'b0);
    exp_q.push_back(8'h3F);
    send_byte(8'h03, 1'b1);
    wait_resp();
    send_byte(8'h57, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_q.push_back(8'h3F);
    send_byte(8'h99, 1'b1);
    wait_resp();
    exp_q.push_back(8'h3F);
    send_byte(8'h52, 1'b1);
    wait_resp();
    chk("perr_no_write", wr_cnt - w0, 0);
    chk("regs_after_perr", regs, model_flat());
    do_read(8'h03);

    // Inter-byte timeout abandons the frame silently
    do_write(8'h01, 8'h77);
    t0 = tx_cnt;
    w0 = wr_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (60) @(posedge clk);
    chk("to_no_tx", tx_cnt - t0, 0);
    chk("to_no_write", wr_cnt - w0, 0);
    do_read(8'h01);

    // Back-pressure, then a byte arriving mid-response is ignored
    send_byte(8'h52, 1'b0);
    exp_q.push_back(model[3]);
    tx_hold = 1'b1;
    send_byte(8'h03, 1'b0);
    t0 = tx_cnt;
    repeat (10) @(posedge clk);
    chk("bp_hold_no_tx", tx_cnt - t0, 0);
    busy_len = 20;
    #1 tx_hold = 1'b0;
    n = 0;
    while (tx_cnt == t0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_tx_after_release", tx_cnt - t0, 1);
    send_byte(8'h00, 1'b0);
    wait_resp();
    repeat (20) @(posedge clk);
    chk("bp_single_tx", tx_cnt - t0, 1);
    busy_len = 5;

    // Asynchronous reset in the middle of a write frame
    send_byte(8'h57, 1'b0);
    send_byte(8'h02, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_regs", regs, 0);
    chk("midrst_tx_en", tx_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_tx_dfifo", tx_dfifo, 0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    exp_q.push_back(8'h3F);
    send_byte(8'hFF, 1'b0);
    wait_resp();
    do_read(8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
